// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART command-frame decoder: FSM state encodings,
// error cause codes, the default frame header and the checksum rule.
package uart_frame_pkg;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADDR = 3'd1;
  localparam logic [2:0] DATH = 3'd2;
  localparam logic [2:0] DATL = 3'd3;
  localparam logic [2:0] SUM  = 3'd4;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_SUM  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  localparam logic [7:0] DEFAULT_HEADER = 8'hAA;

  // Frame checksum: modulo-256 sum of the three payload bytes.
  function automatic logic [7:0] frame_sum(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [7:0] c);
    return a + b + c;
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts enabled cycles since the last clear and flags
// when TIMEOUT_CYCLES-1 is reached. The count saturates instead of wrapping.
module uart_gap_timer #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of block ordering.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/uart_frame_rx.sv
// Command-frame decoder behind uart_byte_rx: assembles HEADER/ADDR/DATA_H/
// DATA_L/SUM frames and issues one register write per frame with a good checksum.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] HEADER         = DEFAULT_HEADER,
  parameter int         TIMEOUT_CYCLES = 20000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [7:0]  data_byte,
  input  logic        Rx_Done,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_data,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [7:0] addr_r;
  logic [7:0] dh_r;
  logic [7:0] dl_r;
  logic       expired;
  logic       timeout;
  logic       sum_byte;
  logic       sum_ok;

  // A byte arriving on the expiry cycle keeps the frame alive.
  assign timeout  = (state != IDLE) && expired && !Rx_Done;
  assign sum_byte = Rx_Done && (state == SUM);
  assign sum_ok   = (data_byte == frame_sum(addr_r, dh_r, dl_r));

  // NOTE: state_nxt gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = IDLE;
    end else if (Rx_Done) begin
      case (state)
        IDLE:    if (data_byte == HEADER) state_nxt = ADDR;
        ADDR:    state_nxt = DATH;
        DATH:    state_nxt = DATL;
        DATL:    state_nxt = SUM;
        SUM:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  uart_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .clr     (Rx_Done || (state_nxt == IDLE)),
    .en      (state != IDLE),
    .expired (expired)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the payload latches are reset too, so a frame cut short by reset
  // can never leak stale bytes into the next checksum.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      addr_r <= '0;
      dh_r   <= '0;
      dl_r   <= '0;
    end else if (Rx_Done) begin
      case (state)
        ADDR:    addr_r <= data_byte;
        DATH:    dh_r   <= data_byte;
        DATL:    dl_r   <= data_byte;
        default: ;
      endcase
    end
  end

  // Pulses default low; a checksum result and a timeout are mutually exclusive.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      reg_addr    <= '0;
      reg_data    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (sum_byte) begin
        if (sum_ok) begin
          reg_addr    <= addr_r;
          reg_data    <= {dh_r, dl_r};
          frame_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
          err_code  <= ERR_SUM;
        end
      end else if (timeout) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TMO;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Direct-strobe bench for uart_frame_rx: scenario tasks plus randomized
// traffic, checked every cycle against a byte-position reference model.
module tb_uart_frame_rx;

  localparam int         T   = 8;
  localparam logic [7:0] HDR = 8'hAA;

  logic        Clk   = 1'b0;
  logic        Rst_n = 1'b1;
  logic [7:0]  data_byte = '0;
  logic        Rx_Done   = 1'b0;
  logic [7:0]  reg_addr;
  logic [15:0] reg_data;
  logic        frame_valid;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;

  uart_frame_rx #(
    .HEADER         (HDR),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .data_byte   (data_byte),
    .Rx_Done     (Rx_Done),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .busy        (busy)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        fv;
    logic        fe;
    logic [1:0]  code;
    logic        busy;
    logic [7:0]  addr;
    logic [15:0] data;
  } outs_t;

  int    n_checks = 0;
  int    n_pass   = 0;
  outs_t exp_o;
  outs_t rec_obs[$];
  outs_t rec_exp[$];

  // Reference model: how many frame bytes are held, the bytes themselves,
  // and idle cycles since the last byte of an open frame.
  int         m_pos;
  int         m_since;
  logic [7:0] m_fb[5];

  function automatic outs_t observe();
    return outs_t'({frame_valid, frame_err, err_code, busy, reg_addr, reg_data});
  endfunction

  task automatic model_reset();
    exp_o   = '0;
    m_pos   = 0;
    m_since = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    exp_o.fv = 1'b0;
    exp_o.fe = 1'b0;
    if (v) begin
      m_since = 0;
      if (m_pos == 0) begin
        if (b == HDR) m_pos = 1;
      end else begin
        m_fb[m_pos] = b;
        m_pos++;
        if (m_pos == 5) begin
          if ((int'(m_fb[1]) + int'(m_fb[2]) + int'(m_fb[3])) % 256 == int'(m_fb[4])) begin
            exp_o.fv   = 1'b1;
            exp_o.addr = m_fb[1];
            exp_o.data = {m_fb[2], m_fb[3]};
          end else begin
            exp_o.fe   = 1'b1;
            exp_o.code = 2'b01;
          end
          m_pos = 0;
        end
      end
    end else if (m_pos > 0) begin
      m_since++;
      if (m_since >= T) begin
        exp_o.fe   = 1'b1;
        exp_o.code = 2'b10;
        m_pos      = 0;
      end
    end
    exp_o.busy = (m_pos > 0);
  endtask

  // One clock: drive on the falling edge, record DUT and model just after the rising edge.
  task automatic cycle(input logic v, input logic [7:0] b);
    @(negedge Clk);
    Rx_Done   = v;
    data_byte = v ? b : 8'($urandom);
    if (Rst_n) model_step(v, b);
    else       model_reset();
    @(posedge Clk);
    #1;
    rec_obs.push_back(observe());
    rec_exp.push_back(exp_o);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) cycle(1'b0, 8'h00);
    cycle(1'b1, b);
  endtask

  function automatic int rgap();
    if ($urandom_range(0, 15) == 0) return int'($urandom_range(T - 1, T));
    return int'($urandom_range(0, 2));
  endfunction

  task automatic test_reset();
    #1 Rst_n = 1'b0;
    model_reset();
    repeat (2) cycle(1'b0, 8'h00);
    n_checks++;
    if (observe() !== outs_t'(0)) $display("FAIL reset_values: got %h expected 0", observe());
    else n_pass++;
    foreach (rec_obs[i]) begin
      n_checks++;
      if (rec_obs[i] !== rec_exp[i]) $display("FAIL reset cycle %0d: got %h expected %h", i, rec_obs[i], rec_exp[i]);
      else n_pass++;
    end
    rec_obs.delete(); rec_exp.delete();
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_good_frame();
    logic [7:0] f[5] = '{8'hAA, 8'h12, 8'h34, 8'h56, 8'h9C};
    int fv_cnt = 0, fe_cnt = 0;
    for (int i = 0; i < 5; i++) send(f[i], i % 3);
    cycle(1'b0, 8'h00);
    foreach (rec_obs[i]) begin
      n_checks++;
      if (rec_obs[i] !== rec_exp[i]) $display("FAIL good_frame cycle %0d: got %h expected %h", i, rec_obs[i], rec_exp[i]);
      else n_pass++;
      fv_cnt += int'(rec_obs[i].fv);
      fe_cnt += int'(rec_obs[i].fe);
    end
    n_checks++;
    if (reg_addr !== 8'h12 || reg_data !== 16'h3456 || fv_cnt != 1 || fe_cnt != 0)
      $display("FAIL good_frame_result: got addr=%h data=%h pulses=%0d errs=%0d expected addr=12 data=3456 pulses=1 errs=0",
               reg_addr, reg_data, fv_cnt, fe_cnt);
    else n_pass++;
    n_checks++;
    if (rec_obs[rec_obs.size() - 2].fv !== 1'b1)
      $display("FAIL good_frame_latency: got fv=%b expected 1 one cycle after SUM strobe", rec_obs[rec_obs.size() - 2].fv);
    else n_pass++;
    rec_obs.delete(); rec_exp.delete();
  endtask

  task automatic test_bad_sum();
    logic [7:0] f[5] = '{8'hAA, 8'h12, 8'h34, 8'h56, 8'h9D};
    int fv_cnt = 0, fe_cnt = 0;
    for (int i = 0; i < 5; i++) send(f[i], 1);
    cycle(1'b0, 8'h00);
    foreach (rec_obs[i]) begin
      n_checks++;
      if (rec_obs[i] !== rec_exp[i]) $display("FAIL bad_sum cycle %0d: got %h expected %h", i, rec_obs[i], rec_exp[i]);
      else n_pass++;
      fv_cnt += int'(rec_obs[i].fv);
      fe_cnt += int'(rec_obs[i].fe);
    end
    n_checks++;
    if (err_code !== 2'b01 || reg_addr !== 8'h12 || reg_data !== 16'h3456 || fv_cnt != 0 || fe_cnt != 1)
      $display("FAIL bad_sum_result: got code=%b addr=%h data=%h valids=%0d errs=%0d expected code=01 addr=12 data=3456 valids=0 errs=1",
               err_code, reg_addr, reg_data, fv_cnt, fe_cnt);
    else n_pass++;
    rec_obs.delete(); rec_exp.delete();
  endtask

  task automatic test_header_payload();
    logic [7:0] f[8] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hFE};
    int fv_cnt = 0;
    for (int i = 0; i < 8; i++) send(f[i], 0);
    cycle(1'b0, 8'h00);
    foreach (rec_obs[i]) begin
      n_checks++;
      if (rec_obs[i] !== rec_exp[i]) $display("FAIL header_payload cycle %0d: got %h expected %h", i, rec_obs[i], rec_exp[i]);
      else n_pass++;
      fv_cnt += int'(rec_obs[i].fv);
    end
    n_checks++;
    if (reg_addr !== 8'hAA || reg_data !== 16'hAAAA || fv_cnt != 1)
      $display("FAIL header_payload_result: got addr=%h data=%h pulses=%0d expected addr=aa data=aaaa pulses=1",
               reg_addr, reg_data, fv_cnt);
    else n_pass++;
    rec_obs.delete(); rec_exp.delete();
  endtask

  task automatic test_timeout();
    logic [7:0] f[5] = '{8'hAA, 8'h01, 8'h00, 8'h02, 8'h03};
    send(8'hAA, 0);
    send(8'h12, 0);
    repeat (T + 2) cycle(1'b0, 8'h00);
    n_checks++;
    if (err_code !== 2'b10 || busy !== 1'b0)
      $display("FAIL timeout_result: got code=%b busy=%b expected code=10 busy=0", err_code, busy);
    else n_pass++;
    for (int i = 0; i < 5; i++) send(f[i], 0);
    cycle(1'b0, 8'h00);
    foreach (rec_obs[i]) begin
      n_checks++;
      if (rec_obs[i] !== rec_exp[i]) $display("FAIL timeout cycle %0d: got %h expected %h", i, rec_obs[i], rec_exp[i]);
      else n_pass++;
    end
    n_checks++;
    if (reg_addr !== 8'h01 || reg_data !== 16'h0002)
      $display("FAIL timeout_recover: got addr=%h data=%h expected addr=01 data=0002", reg_addr, reg_data);
    else n_pass++;
    rec_obs.delete(); rec_exp.delete();
  endtask

  task automatic test_expiry_boundary();
    int fe_cnt = 0;
    send(8'hAA, 0);
    send(8'h10, T - 1);
    send(8'h20, T - 1);
    send(8'h30, T - 1);
    send(8'h60, T - 1);
    cycle(1'b0, 8'h00);
    foreach (rec_obs[i]) begin
      n_checks++;
      if (rec_obs[i] !== rec_exp[i]) $display("FAIL expiry_edge cycle %0d: got %h expected %h", i, rec_obs[i], rec_exp[i]);
      else n_pass++;
      fe_cnt += int'(rec_obs[i].fe);
    end
    n_checks++;
    if (fe_cnt != 0 || reg_addr !== 8'h10 || reg_data !== 16'h2030)
      $display("FAIL expiry_edge_result: got errs=%0d addr=%h data=%h expected errs=0 addr=10 data=2030",
               fe_cnt, reg_addr, reg_data);
    else n_pass++;
    rec_obs.delete(); rec_exp.delete();
    fe_cnt = 0;
    send(8'hAA, 0);
    send(8'h11, T);
    cycle(1'b0, 8'h00);
    foreach (rec_obs[i]) begin
      n_checks++;
      if (rec_obs[i] !== rec_exp[i]) $display("FAIL expiry_late cycle %0d: got %h expected %h", i, rec_obs[i], rec_exp[i]);
      else n_pass++;
      fe_cnt += int'(rec_obs[i].fe);
    end
    n_checks++;
    if (fe_cnt != 1 || err_code !== 2'b10 || busy !== 1'b0)
      $display("FAIL expiry_late_result: got errs=%0d code=%b busy=%b expected errs=1 code=10 busy=0", fe_cnt, err_code, busy);
    else n_pass++;
    rec_obs.delete(); rec_exp.delete();
  endtask

  task automatic test_reset_mid_frame();
    int fv_cnt = 0;
    send(8'hAA, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    n_checks++;
    if (observe() !== outs_t'(0)) $display("FAIL reset_async: got %h expected 0", observe());
    else n_pass++;
    model_reset();
    repeat (3) cycle(1'b0, 8'h00);
    Rst_n = 1'b1;
    send(8'h56, 0);
    send(8'h9C, 0);
    cycle(1'b0, 8'h00);
    foreach (rec_obs[i]) begin
      n_checks++;
      if (rec_obs[i] !== rec_exp[i]) $display("FAIL reset_mid cycle %0d: got %h expected %h", i, rec_obs[i], rec_exp[i]);
      else n_pass++;
      fv_cnt += int'(rec_obs[i].fv);
    end
    n_checks++;
    if (fv_cnt != 1 - 1 + 0 || observe() !== outs_t'(0))
      $display("FAIL reset_mid_result: got valids=%0d outs=%h expected valids=0 outs=0", fv_cnt, observe());
    else n_pass++;
    rec_obs.delete(); rec_exp.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, h, l;
    int fv_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      a = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
      send(HDR, 0); send(a, 0); send(h, 0); send(l, 0); send(a + h + l, 0);
    end
    cycle(1'b0, 8'h00);
    foreach (rec_obs[i]) begin
      n_checks++;
      if (rec_obs[i] !== rec_exp[i]) $display("FAIL back_to_back cycle %0d: got %h expected %h", i, rec_obs[i], rec_exp[i]);
      else n_pass++;
      fv_cnt += int'(rec_obs[i].fv);
    end
    n_checks++;
    if (fv_cnt != 4) $display("FAIL back_to_back_count: got %0d valids expected 4", fv_cnt);
    else n_pass++;
    rec_obs.delete(); rec_exp.delete();
  endtask

  task automatic test_random();
    logic [7:0] a, h, l, s;
    int kind;
    for (int f = 0; f < 150; f++) begin
      kind = int'($urandom_range(0, 3));
      if (kind == 0) begin
        send(8'($urandom), rgap());
      end else begin
        a = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
        s = a + h + l;
        if (kind == 1) s = s ^ 8'($urandom_range(1, 255));
        send(HDR, rgap()); send(a, rgap()); send(h, rgap()); send(l, rgap()); send(s, rgap());
      end
    end
    repeat (T + 2) cycle(1'b0, 8'h00);
    foreach (rec_obs[i]) begin
      n_checks++;
      if (rec_obs[i] !== rec_exp[i]) $display("FAIL random cycle %0d: got %h expected %h", i, rec_obs[i], rec_exp[i]);
      else n_pass++;
    end
    rec_obs.delete(); rec_exp.delete();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_good_frame();
    test_bad_sum();
    test_header_payload();
    test_timeout();
    test_expiry_boundary();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
Command-frame decoder placed directly downstream of uart_byte_rx. It consumes the data_byte/Rx_Done byte stream and assembles fixed 5-byte frames: HEADER, ADDR, DATA_H, DATA_L, SUM. On a valid frame it presents one register-write command (8-bit address, 16-bit data). Malformed frames and stalled frames raise a one-cycle error pulse with a cause code. The output feeds the team's register-bank write port.

Parameters:
HEADER, 8'hAA, frame start byte.
TIMEOUT_CYCLES, 20000, max Clk cycles allowed between consecutive bytes inside a frame (about 4.6 byte times at 115200 baud, 50 MHz).

Ports:
Clk  input  1  system clock, 50 MHz.
Rst_n  input  1  asynchronous active-low reset.
data_byte  input  8  received byte from uart_byte_rx; valid only while Rx_Done=1.
Rx_Done  input  1  one-cycle strobe, byte available.
reg_addr  output  8  address of the last good frame.
reg_data  output  16  data of the last good frame, {DATA_H, DATA_L}.
frame_valid  output  1  one-cycle pulse when reg_addr/reg_data update.
frame_err  output  1  one-cycle pulse on a frame error.
err_code  output  2  cause of the last error: 01 checksum, 10 timeout. Holds until the next error.
busy  output  1  high while in any state other than IDLE.

Behaviour:
- One clock (Clk). Reset is asynchronous and active-low (Rst_n). All state is cleared on Rst_n=0 regardless of Clk.
- Reset values: reg_addr=0, reg_data=0, frame_valid=0, frame_err=0, err_code=00, busy=0, state=IDLE, timer=0.
- FSM states and transitions (each transition is taken only on a cycle with Rx_Done=1, except timeout):
  - IDLE: if data_byte==HEADER go to ADDR; any other byte is ignored, with no error.
  - ADDR: latch addr_r and go to DATH.
  - DATH: latch dh_r and go to DATL.
  - DATL: latch dl_r and go to SUM.
  - SUM: compare data_byte with (addr_r+dh_r+dl_r) mod 256, then return to IDLE.
- Payload bytes equal to HEADER are plain data; there is no resync inside a frame.
- Checksum match: reg_addr<=addr_r and reg_data<={dh_r,dl_r} on the clock edge that samples the SUM byte. frame_valid is high for exactly the following cycle, which gives 1-cycle latency from the Rx_Done of SUM.
- Checksum mismatch: reg_addr and reg_data are unchanged. frame_err pulses for 1 cycle with the same timing as frame_valid, and err_code<=01.
- Timeout:
  - The gap timer is cleared on every Rx_Done and on entry to IDLE. It counts each cycle while state≠IDLE.
  - When the timer reaches TIMEOUT_CYCLES-1 with no Rx_Done, the block returns to IDLE, pulses frame_err, and sets err_code<=10. Partial data is discarded.
- Simultaneous Rx_Done and timeout in the same cycle: Rx_Done wins. The byte is processed and the timer cleared.
- frame_valid and frame_err are never high in the same cycle.
- busy=(state≠IDLE), combinational from the state register.
- Timer width is $clog2(TIMEOUT_CYCLES) and saturates; it never wraps.
- Reset mid-frame: the block returns to IDLE and all latched partial bytes are discarded. The next frame must begin with HEADER.

Decomposition:
- Package uart_frame_pkg holds:
  - state encodings IDLE/ADDR/DATH/DATL/SUM (3-bit localparams);
  - error codes ERR_NONE=00, ERR_SUM=01, ERR_TMO=10;
  - default HEADER.
- One sub-module, uart_gap_timer, containing the clear, enable and expired flag, parameterised by TIMEOUT_CYCLES. The FSM, byte latches and checksum stay in uart_frame_rx.
- The bench reuses uart_byte_tx → uart_byte_rx (baud_set=4) to drive the block serially. A direct-strobe bench is also required for fast timing checks.

Test Plan:
1. Good frame: bytes AA 12 34 56 9C → reg_addr=0x12, reg_data=0x3456, a single frame_valid pulse 1 cycle after the last Rx_Done, frame_err stays 0.
2. Bad checksum: AA 12 34 56 9D → frame_err pulse, err_code=01, reg_addr/reg_data keep their previous values, no frame_valid.
3. Leading garbage, then a header-valued payload: 00 FF 55 AA AA AA AA FE → pre-header bytes are ignored; reg_addr=0xAA, reg_data=0xAAAA, frame_valid.
4. Timeout: AA 12, then no strobe for TIMEOUT_CYCLES cycles → frame_err, err_code=10, busy drops. A following AA 01 00 02 03 gives reg_addr=0x01, reg_data=0x0002.
5. Boundary: with TIMEOUT_CYCLES=8 on the direct bench, issue AA, then Rx_Done on exactly the expiry cycle → no error, and the frame completes normally.
6. Reset mid-frame: AA 12 34, Rst_n low for 3 cycles, then 56 9C → no frame_valid. All outputs read reset values throughout; busy=0 after reset.
